// File: rtl/gemm_operand_loader.sv
// Serial-to-parallel operand stage for the GEMM engine: collects alpha, beta, A, B, C
// from one word stream, fires a one-cycle start, and holds operands until the engine is done.
module gemm_operand_loader #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4
) (
    input  logic                         iclk,
    input  logic                         irst,
    input  logic                         ivalid,
    input  logic [DATA_WIDTH-1:0]        idata,
    input  logic                         ilast,
    output logic                         oready,
    input  logic                         igemm_busy,
    input  logic                         igemm_done,
    output logic                         ostart,
    output logic [DATA_WIDTH-1:0]        oalpha,
    output logic [DATA_WIDTH-1:0]        obeta,
    output logic signed [DATA_WIDTH-1:0] oa_matrix [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic signed [DATA_WIDTH-1:0] ob_matrix [MATRIX_ADJUST][MATRIX_WIDTH],
    output logic signed [DATA_WIDTH-1:0] oc_matrix [MATRIX_HEIGHT][MATRIX_ADJUST],
    output logic                         oerr,
    output logic [15:0]                  oframes,
    output logic [1:0]                   odbg_state
);
    localparam int N    = 2 + MATRIX_HEIGHT * MATRIX_WIDTH + MATRIX_ADJUST * MATRIX_WIDTH
                            + MATRIX_HEIGHT * MATRIX_ADJUST;
    localparam int KW   = $clog2(N);
    localparam int MAXD = (MATRIX_HEIGHT > MATRIX_WIDTH)
                            ? ((MATRIX_HEIGHT > MATRIX_ADJUST) ? MATRIX_HEIGHT : MATRIX_ADJUST)
                            : ((MATRIX_WIDTH > MATRIX_ADJUST) ? MATRIX_WIDTH : MATRIX_ADJUST);
    localparam int IW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT} state_t;
    typedef enum logic [2:0] {SEG_ALPHA, SEG_BETA, SEG_A, SEG_B, SEG_C} seg_t;

    state_t          state_q, state_d;
    seg_t            seg_q, seg_d;
    logic [KW-1:0]   k_q, k_d;
    logic [IW-1:0]   row_q, row_d, col_q, col_d;
    logic [IW-1:0]   row_max, col_max;
    logic            err_q;
    logic [15:0]     frames_q;

    logic [DATA_WIDTH-1:0]        alpha_q, beta_q;
    logic signed [DATA_WIDTH-1:0] a_q [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic signed [DATA_WIDTH-1:0] b_q [MATRIX_ADJUST][MATRIX_WIDTH];
    logic signed [DATA_WIDTH-1:0] c_q [MATRIX_HEIGHT][MATRIX_ADJUST];

    logic accept, k_last, frame_end, frame_err;

    // Handshake: a word moves when ivalid && oready in the same cycle; oready depends only
    // on the registered state (and reset), never on ivalid or idata.
    assign oready    = (state_q == S_LOAD) && !irst;
    assign ostart    = (state_q == S_FIRE) && !igemm_busy && !irst;
    assign accept    = ivalid && oready;
    assign k_last    = (k_q == KW'(N - 1));
    assign frame_end = accept && ilast && k_last;
    assign frame_err = accept && (ilast != k_last);

    always_comb begin
        row_max = IW'(MATRIX_HEIGHT - 1);
        col_max = IW'(MATRIX_WIDTH - 1);
        case (seg_q)
            SEG_B: begin
                row_max = IW'(MATRIX_ADJUST - 1);
                col_max = IW'(MATRIX_WIDTH - 1);
            end
            SEG_C: begin
                row_max = IW'(MATRIX_HEIGHT - 1);
                col_max = IW'(MATRIX_ADJUST - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (frame_end) state_d = S_FIRE;
            S_FIRE:  if (!igemm_busy) state_d = S_WAIT;
            S_WAIT:  if (igemm_done) state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    // Index walk: k counts words, seg/row/col point at the destination register directly.
    always_comb begin
        seg_d = seg_q;
        k_d   = k_q;
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (frame_end || frame_err) begin
                seg_d = SEG_ALPHA;
                k_d   = '0;
                row_d = '0;
                col_d = '0;
            end else begin
                k_d = k_q + KW'(1);
                case (seg_q)
                    SEG_ALPHA: seg_d = SEG_BETA;
                    SEG_BETA: begin
                        seg_d = SEG_A;
                        row_d = '0;
                        col_d = '0;
                    end
                    default: begin
                        if (col_q == col_max) begin
                            col_d = '0;
                            if (row_q == row_max) begin
                                row_d = '0;
                                seg_d = (seg_q == SEG_A) ? SEG_B : SEG_C;
                            end else begin
                                row_d = row_q + IW'(1);
                            end
                        end else begin
                            col_d = col_q + IW'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= S_LOAD;
            seg_q    <= SEG_ALPHA;
            k_q      <= '0;
            row_q    <= '0;
            col_q    <= '0;
            err_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            err_q   <= frame_err;
            if (ostart) frames_q <= frames_q + 16'd1;
        end
    end

    // Error words are still written; only a clean frame makes the operand set meaningful.
    always_ff @(posedge iclk) begin
        if (irst) begin
            alpha_q <= '0;
            beta_q  <= '0;
            for (int r = 0; r < MATRIX_HEIGHT; r++)
                for (int c = 0; c < MATRIX_WIDTH; c++) a_q[r][c] <= '0;
            for (int r = 0; r < MATRIX_ADJUST; r++)
                for (int c = 0; c < MATRIX_WIDTH; c++) b_q[r][c] <= '0;
            for (int r = 0; r < MATRIX_HEIGHT; r++)
                for (int c = 0; c < MATRIX_ADJUST; c++) c_q[r][c] <= '0;
        end else if (accept) begin
            case (seg_q)
                SEG_ALPHA: alpha_q <= idata;
                SEG_BETA:  beta_q <= idata;
                SEG_A:     a_q[row_q][col_q] <= idata;
                SEG_B:     b_q[row_q][col_q] <= idata;
                default:   c_q[row_q][col_q] <= idata;
            endcase
        end
    end

    assign oalpha     = alpha_q;
    assign obeta      = beta_q;
    assign oa_matrix  = a_q;
    assign ob_matrix  = b_q;
    assign oc_matrix  = c_q;
    assign oerr       = err_q;
    assign oframes    = frames_q;
    assign odbg_state = state_q;

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Self-checking bench for gemm_operand_loader: drives framed word streams and compares the
// DUT against an index-arithmetic model of where each word lands.
module tb_gemm_operand_loader;
    localparam int DW = 64;
    localparam int MW = 4;
    localparam int MH = 4;
    localparam int MA = 4;
    localparam int N  = 2 + MH * MW + MA * MW + MH * MA;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          ivalid = 1'b0;
    logic          ilast = 1'b0;
    logic          igemm_busy = 1'b0;
    logic          igemm_done = 1'b0;
    logic [DW-1:0] idata = '0;
    logic          oready, ostart, oerr;
    logic [DW-1:0] oalpha, obeta;
    logic signed [DW-1:0] oa_matrix [MH][MW];
    logic signed [DW-1:0] ob_matrix [MA][MW];
    logic signed [DW-1:0] oc_matrix [MH][MA];
    logic [15:0]   oframes;
    logic [1:0]    odbg_state;

    gemm_operand_loader #(
        .DATA_WIDTH(DW), .MATRIX_WIDTH(MW), .MATRIX_HEIGHT(MH), .MATRIX_ADJUST(MA)
    ) dut (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .idata(idata), .ilast(ilast),
        .oready(oready), .igemm_busy(igemm_busy), .igemm_done(igemm_done),
        .ostart(ostart), .oalpha(oalpha), .obeta(obeta), .oa_matrix(oa_matrix),
        .ob_matrix(ob_matrix), .oc_matrix(oc_matrix), .oerr(oerr), .oframes(oframes),
        .odbg_state(odbg_state)
    );

    always #5 iclk = ~iclk;

    // Reference model
    logic [DW-1:0] m_alpha, m_beta;
    logic [DW-1:0] m_a [MH][MW];
    logic [DW-1:0] m_b [MA][MW];
    logic [DW-1:0] m_c [MH][MA];
    int            m_k = 0;
    int            m_frames = 0;
    logic [DW-1:0] frame_q[$];

    int   tests = 0;
    int   fails = 0;
    int   word_mism = 0;
    bit   clean_last;
    int   start_cycles, start_at, ready_bad, ops_bad;
    logic ready_after;
    logic rst_ready_during, rst_start_during, rst_ready_after;
    int   rst_bad;

    function automatic void model_clear();
        m_alpha = '0;
        m_beta  = '0;
        for (int r = 0; r < MH; r++) for (int c = 0; c < MW; c++) m_a[r][c] = '0;
        for (int r = 0; r < MA; r++) for (int c = 0; c < MW; c++) m_b[r][c] = '0;
        for (int r = 0; r < MH; r++) for (int c = 0; c < MA; c++) m_c[r][c] = '0;
        m_k = 0;
        m_frames = 0;
    endfunction

    function automatic void model_write(input int k, input logic [DW-1:0] d);
        int i;
        if (k == 0) m_alpha = d;
        else if (k == 1) m_beta = d;
        else begin
            i = k - 2;
            if (i < MH * MW) m_a[i / MW][i % MW] = d;
            else begin
                i -= MH * MW;
                if (i < MA * MW) m_b[i / MW][i % MW] = d;
                else begin
                    i -= MA * MW;
                    m_c[i / MA][i % MA] = d;
                end
            end
        end
    endfunction

    function automatic int ops_diff();
        int n = 0;
        if (oalpha !== m_alpha) n++;
        if (obeta !== m_beta) n++;
        for (int r = 0; r < MH; r++) for (int c = 0; c < MW; c++) if (oa_matrix[r][c] !== m_a[r][c]) n++;
        for (int r = 0; r < MA; r++) for (int c = 0; c < MW; c++) if (ob_matrix[r][c] !== m_b[r][c]) n++;
        for (int r = 0; r < MH; r++) for (int c = 0; c < MA; c++) if (oc_matrix[r][c] !== m_c[r][c]) n++;
        return n;
    endfunction

    task automatic gen_pattern();
        frame_q.delete();
        frame_q.push_back(64'd2);
        frame_q.push_back(64'd3);
        for (int r = 0; r < MH; r++) for (int c = 0; c < MW; c++) frame_q.push_back(DW'(r * 4 + c));
        for (int r = 0; r < MA; r++) for (int c = 0; c < MW; c++) frame_q.push_back((r == c) ? 64'd1 : 64'd0);
        for (int i = 0; i < MH * MA; i++) frame_q.push_back(64'h10);
    endtask

    task automatic gen_random();
        frame_q.delete();
        for (int i = 0; i < N; i++) frame_q.push_back({$urandom, $urandom});
    endtask

    // Drives one word (after 'gap' idle cycles) and updates the model; oerr and oready
    // deviations are tallied in word_mism.
    task automatic push_word(input logic [DW-1:0] d, input logic last, input int gap);
        bit exp_err;
        for (int g = 0; g < gap; g++) begin
            @(posedge iclk); #1;
            if (oerr !== 1'b0) word_mism++;
        end
        ivalid = 1'b1;
        idata  = d;
        ilast  = last;
        if (oready !== 1'b1) word_mism++;
        @(posedge iclk); #1;
        ivalid = 1'b0;
        ilast  = 1'b0;
        model_write(m_k, d);
        exp_err    = (last && m_k != N - 1) || (!last && m_k == N - 1);
        clean_last = last && (m_k == N - 1);
        m_k = (exp_err || clean_last) ? 0 : m_k + 1;
        if (oerr !== exp_err) word_mism++;
    endtask

    task automatic send_frame(input int nwords, input int last_at, input int gapmode);
        int gap;
        for (int i = 0; i < nwords; i++) begin
            gap = (gapmode == 1 && i > 0) ? 2 : (gapmode == 2) ? int'($urandom_range(0, 2)) : 0;
            push_word(frame_q[i], (i == last_at), gap);
        end
    endtask

    // Entered one cycle after the last word; drives junk words throughout FIRE/WAIT.
    task automatic run_job(input int busy_cycles, input int wait_cycles);
        start_cycles = 0;
        start_at     = -1;
        ready_bad    = 0;
        ops_bad      = 0;
        igemm_done   = 1'b0;
        ivalid       = 1'b1;
        idata        = {$urandom, $urandom};
        for (int c = 0; c < busy_cycles + 1 + wait_cycles; c++) begin
            if (c == busy_cycles) igemm_busy = 1'b0;
            #1;
            if (ostart === 1'b1) begin
                start_cycles++;
                if (start_at < 0) start_at = c;
            end
            if (oready !== 1'b0) ready_bad++;
            if (ops_diff() != 0) ops_bad++;
            @(posedge iclk); #1;
            idata = {$urandom, $urandom};
        end
        igemm_done = 1'b1;
        #1;
        if (oready !== 1'b0) ready_bad++;
        @(posedge iclk); #1;
        igemm_done = 1'b0;
        ivalid     = 1'b0;
        ready_after = oready;
        if (ops_diff() != 0) ops_bad++;
        if (start_at >= 0) m_frames++;
    endtask

    task automatic do_reset();
        irst = 1'b1;
        ivalid = 1'b0;
        ilast = 1'b0;
        igemm_busy = 1'b0;
        igemm_done = 1'b0;
        #1;
        rst_ready_during = oready;
        rst_start_during = ostart;
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        model_clear();
        rst_bad = ops_diff() + int'(oframes !== 16'd0) + int'(oerr !== 1'b0)
                + int'(ostart !== 1'b0) + int'(oready !== 1'b0);
        irst = 1'b0;
        #1;
        rst_ready_after = oready;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (rst_ready_during !== 1'b0) begin fails++; $display("FAIL reset_ready_during: got %b want 0", rst_ready_during); end
        tests++; if (rst_bad !== 0) begin fails++; $display("FAIL reset_values: %0d outputs off, want 0", rst_bad); end
        tests++; if (rst_ready_after !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", rst_ready_after); end
    endtask

    task automatic test_clean_frame();
        word_mism = 0;
        gen_pattern();
        send_frame(N, N - 1, 0);
        tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL clean_ops: %0d operands differ, want 0", ops_diff()); end
        run_job(0, 3);
        tests++; if (start_at !== 0) begin fails++; $display("FAIL clean_start_at: got %0d want 0", start_at); end
        tests++; if (start_cycles !== 1) begin fails++; $display("FAIL clean_start_len: got %0d want 1", start_cycles); end
        tests++; if (ops_bad !== 0 || ready_bad !== 0) begin fails++; $display("FAIL clean_hold: ops_bad %0d ready_bad %0d want 0 0", ops_bad, ready_bad); end
        tests++; if (ready_after !== 1'b1) begin fails++; $display("FAIL clean_ready_after_done: got %b want 1", ready_after); end
        tests++; if (oframes !== 16'(m_frames)) begin fails++; $display("FAIL clean_frames: got %0d want %0d", oframes, m_frames); end
        tests++; if (word_mism !== 0) begin fails++; $display("FAIL clean_words: %0d word deviations want 0", word_mism); end
    endtask

    task automatic test_backpressure();
        word_mism = 0;
        gen_pattern();
        frame_q[0] = 64'd7;
        igemm_done = 1'b1;
        send_frame(N, N - 1, 1);
        tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL bp_ops: %0d operands differ, want 0", ops_diff()); end
        run_job(0, 4);
        tests++; if (start_at !== 0 || start_cycles !== 1) begin fails++; $display("FAIL bp_start: at %0d len %0d want 0 1", start_at, start_cycles); end
        tests++; if (ops_bad !== 0 || ready_bad !== 0) begin fails++; $display("FAIL bp_hold: ops_bad %0d ready_bad %0d want 0 0", ops_bad, ready_bad); end
        tests++; if (oframes !== 16'(m_frames)) begin fails++; $display("FAIL bp_frames: got %0d want %0d", oframes, m_frames); end
        tests++; if (word_mism !== 0) begin fails++; $display("FAIL bp_words: %0d word deviations want 0", word_mism); end
    endtask

    task automatic test_early_last(input int pos);
        word_mism = 0;
        gen_random();
        send_frame(pos + 1, pos, 0);
        #1;
        tests++; if (oerr !== 1'b1) begin fails++; $display("FAIL early_err_pulse: got %b want 1", oerr); end
        tests++; if (oready !== 1'b1 || ostart !== 1'b0) begin fails++; $display("FAIL early_state: ready %b start %b want 1 0", oready, ostart); end
        tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL early_ops: %0d operands differ, want 0", ops_diff()); end
        @(posedge iclk); #1;
        tests++; if (oerr !== 1'b0) begin fails++; $display("FAIL early_err_len: got %b want 0", oerr); end
        gen_random();
        send_frame(N, N - 1, 0);
        tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL early_next_ops: %0d operands differ, want 0", ops_diff()); end
        run_job(0, 2);
        tests++; if (start_at !== 0 || oframes !== 16'(m_frames)) begin fails++; $display("FAIL early_next_job: start_at %0d frames %0d want 0 %0d", start_at, oframes, m_frames); end
        tests++; if (word_mism !== 0) begin fails++; $display("FAIL early_words: %0d word deviations want 0", word_mism); end
    endtask

    task automatic test_missing_last();
        int frames_before;
        word_mism = 0;
        frames_before = m_frames;
        gen_random();
        send_frame(N, -1, 0);
        #1;
        tests++; if (oerr !== 1'b1) begin fails++; $display("FAIL miss_err_pulse: got %b want 1", oerr); end
        tests++; if (oready !== 1'b1 || ostart !== 1'b0) begin fails++; $display("FAIL miss_state: ready %b start %b want 1 0", oready, ostart); end
        tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL miss_ops: %0d operands differ, want 0", ops_diff()); end
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        tests++; if (ostart !== 1'b0 || oready !== 1'b1 || oframes !== 16'(frames_before)) begin
            fails++; $display("FAIL miss_after: start %b ready %b frames %0d want 0 1 %0d", ostart, oready, oframes, frames_before); end
        tests++; if (word_mism !== 0) begin fails++; $display("FAIL miss_words: %0d word deviations want 0", word_mism); end
    endtask

    task automatic test_busy_holdoff();
        word_mism = 0;
        gen_random();
        igemm_busy = 1'b1;
        send_frame(N, N - 1, 0);
        run_job(5, 3);
        tests++; if (start_at !== 5) begin fails++; $display("FAIL busy_start_at: got %0d want 5", start_at); end
        tests++; if (start_cycles !== 1) begin fails++; $display("FAIL busy_start_len: got %0d want 1", start_cycles); end
        tests++; if (ready_bad !== 0 || ready_after !== 1'b1) begin fails++; $display("FAIL busy_ready: bad %0d after %b want 0 1", ready_bad, ready_after); end
        tests++; if (ops_bad !== 0) begin fails++; $display("FAIL busy_hold: ops_bad %0d want 0", ops_bad); end
        tests++; if (oframes !== 16'(m_frames)) begin fails++; $display("FAIL busy_frames: got %0d want %0d", oframes, m_frames); end
    endtask

    task automatic test_reset_abort();
        // Mid-frame
        gen_random();
        send_frame(31, -1, 0);
        do_reset();
        tests++; if (rst_bad !== 0 || rst_ready_during !== 1'b0 || rst_ready_after !== 1'b1) begin
            fails++; $display("FAIL rst_mid: bad %0d ready_during %b ready_after %b want 0 0 1", rst_bad, rst_ready_during, rst_ready_after); end
        // In FIRE with the engine going idle in the reset cycle
        gen_random();
        igemm_busy = 1'b1;
        send_frame(N, N - 1, 0);
        do_reset();
        tests++; if (rst_start_during !== 1'b0 || rst_bad !== 0) begin
            fails++; $display("FAIL rst_fire: start %b bad %0d want 0 0", rst_start_during, rst_bad); end
        // In WAIT
        gen_random();
        send_frame(N, N - 1, 0);
        #1;
        tests++; if (ostart !== 1'b1) begin fails++; $display("FAIL rst_wait_start: got %b want 1", ostart); end
        @(posedge iclk); #1;
        @(posedge iclk); #1;
        do_reset();
        tests++; if (rst_bad !== 0 || rst_ready_after !== 1'b1) begin
            fails++; $display("FAIL rst_wait: bad %0d ready_after %b want 0 1", rst_bad, rst_ready_after); end
        gen_random();
        send_frame(N, N - 1, 0);
        tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL rst_next_ops: %0d operands differ, want 0", ops_diff()); end
        run_job(0, 2);
        tests++; if (start_at !== 0 || oframes !== 16'd1) begin fails++; $display("FAIL rst_next_job: start_at %0d frames %0d want 0 1", start_at, oframes); end
    endtask

    task automatic test_random_jobs();
        int busy;
        for (int j = 0; j < 4; j++) begin
            word_mism = 0;
            gen_random();
            busy = $urandom_range(0, 3);
            igemm_busy = (busy > 0);
            send_frame(N, N - 1, 2);
            tests++; if (ops_diff() !== 0) begin fails++; $display("FAIL rand_ops[%0d]: %0d operands differ, want 0", j, ops_diff()); end
            run_job(busy, $urandom_range(1, 3));
            tests++; if (start_at !== busy || start_cycles !== 1) begin fails++; $display("FAIL rand_start[%0d]: at %0d len %0d want %0d 1", j, start_at, start_cycles, busy); end
            tests++; if (ops_bad !== 0 || ready_bad !== 0 || ready_after !== 1'b1) begin
                fails++; $display("FAIL rand_hold[%0d]: ops_bad %0d ready_bad %0d ready_after %b want 0 0 1", j, ops_bad, ready_bad, ready_after); end
            tests++; if (oframes !== 16'(m_frames) || word_mism !== 0) begin
                fails++; $display("FAIL rand_frames[%0d]: frames %0d want %0d, word deviations %0d", j, oframes, m_frames, word_mism); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_frame();
        test_backpressure();
        test_early_last(20);
        test_early_last(int'($urandom_range(2, N - 2)));
        test_missing_last();
        test_busy_holdoff();
        test_reset_abort();
        test_random_jobs();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gemm_operand_loader.md
# gemm_operand_loader

Upstream operand stage for the GEMM engine. Accepts one serial word stream per job (alpha, beta, then A, B and C in row-major order) and assembles the words into parallel matrix registers. It then issues a one-cycle start pulse to the GEMM engine and holds every operand stable until the engine reports done. It is the only block that drives the engine's `ialpha`, `ibeta`, `ia_matrix`, `ib_matrix`, `ic_matrix` and `istart` inputs.

## Interface
- DATA_WIDTH, 64, width of every operand word
- MATRIX_WIDTH, 4, columns of A and columns of B
- MATRIX_HEIGHT, 4, rows of A and rows of C
- MATRIX_ADJUST, 4, rows of B and columns of C
- iclk  in  1  clock; all logic on rising edge
- irst  in  1  reset, synchronous, active-high
- ivalid  in  1  input word valid
- idata  in  DATA_WIDTH  input word
- ilast  in  1  marks the final word of a frame
- oready  out  1  block can accept a word this cycle
- igemm_busy  in  1  GEMM engine busy
- igemm_done  in  1  GEMM engine done pulse
- ostart  out  1  one-cycle start pulse to the GEMM engine
- oalpha, obeta  out  DATA_WIDTH each  scale factors
- oa_matrix  out  signed DATA_WIDTH [MATRIX_HEIGHT][MATRIX_WIDTH]
- ob_matrix  out  signed DATA_WIDTH [MATRIX_ADJUST][MATRIX_WIDTH]
- oc_matrix  out  signed DATA_WIDTH [MATRIX_HEIGHT][MATRIX_ADJUST]
- oerr  out  1  one-cycle framing-error pulse
- oframes  out  16  count of jobs started; wraps 0xFFFF→0

## Operation
- Frame length N = 2 + H·W + ADJ·W + H·ADJ. With the defaults, N = 50.
- Word index k runs from 0 to N-1:
  - k=0 is alpha.
  - k=1 is beta.
  - The next H·W words are A[r][c], row-major.
  - The next ADJ·W words are B[r][c], row-major.
  - The last H·ADJ words are C[r][c], row-major.
- Index counter width is $clog2(N). The counter is decoded into a segment select plus row/column counters. There is no division.
- A word is accepted when ivalid && oready. Each accepted word is written to its destination register and k increments.
- Words are stored unmodified, with no sign extension or arithmetic. Width conversion is not this block's job.
- The state machine has three states:
  - LOAD: oready=1. On accepting word k=N-1 with ilast=1, go to FIRE.
  - FIRE: oready=0.
    - If igemm_busy=0: ostart=1 for this cycle, oframes increments, go to WAIT.
    - If igemm_busy=1: ostart=0, stay in FIRE.
  - WAIT: oready=0. Operand outputs are frozen. When igemm_done=1 is sampled, go to LOAD with k=0.
- Framing errors:
  - ilast=1 on an accepted word with k<N-1: the word is still written, oerr pulses, k returns to 0, state stays LOAD and no ostart is issued.
  - Word k=N-1 accepted with ilast=0: same handling (word written, oerr pulse, k=0, stay LOAD, no ostart).
  - After an error, the operand registers hold a partial mix of old and new data. They are only meaningful after a clean frame.
- igemm_done outside WAIT is ignored.
- ivalid is ignored when oready=0, and no word is consumed.

## Timing
- Reset values:
  - state LOAD, k=0.
  - All matrix, alpha and beta registers 0.
  - ostart=0, oerr=0, oframes=0.
  - oready=0 while irst=1; oready=1 on the first cycle after irst deasserts.
- oready and ostart are decoded from the registered state only. There are no combinational paths from ivalid or idata to any output.
- If the last word is accepted in cycle t:
  - Operands are visible from t+1.
  - FIRE is the state in t+1, so ostart=1 in t+1 when the engine is idle.
  - WAIT begins in t+2.
- If igemm_done is sampled high in cycle d, then oready=1 in d+1.
- Minimum job period is N+2+(GEMM latency) cycles.
- oerr is registered: an error word accepted in cycle t gives oerr=1 in t+1 only.
- Operand outputs change only on accepted words. They are constant from ostart through igemm_done.
- irst asserted at any point (mid-frame, in FIRE, or in WAIT) aborts everything and restores the reset values on the next edge. No ostart is issued for an aborted frame.

## Test plan
- Clean frame, defaults: alpha=2, beta=3, A[r][c]=r*4+c, B=identity, C all 0x10, ilast on word 49 → ostart exactly one cycle after word 49, operands match, oframes=1, oerr never high.
- Backpressure and gaps: same frame with ivalid toggling 1-0-0-1 → identical register contents. No word is accepted during FIRE or WAIT even with ivalid=1.
- Early ilast on word 20 → oerr high for one cycle, no ostart, k=0. A following clean frame produces ostart and oframes=1.
- Missing ilast on word 49 → oerr pulse, no ostart, oready stays 1.
- igemm_busy held high for 5 cycles after the last word → ostart held off, then asserted for exactly one cycle in the first cycle busy is low. oready stays 0 until igemm_done, and is 1 in the cycle after done.
- irst asserted after word 30, and separately during WAIT → all outputs return to reset values, oready=0 during reset and 1 after. A subsequent clean frame starts correctly from k=0.
